i2c_slave_regport: RTL and testbench
====================================

Name: i2c_slave_regport

Overview:
- Parametrised successor to the current I2C slave core.
- Standalone I2C target with a configurable 7-bit address, register-pointer protocol, auto-increment with wrap, repeated-START support and input glitch filtering.
- Presents a generic synchronous register-file port, so it can front any RAM controller (32x8 multi-RAM or larger).
- The SDA pad is open-drain; the top level ties `sda = sda_oe ? 1'b0 : 1'bz`, and SCL is input only (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit device address matched after START.
- ADDR_W, 5, register pointer width; depth = 2**ADDR_W.
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer holds.
- FILTER_LEN, 3, consecutive identical clk samples required before an SCL/SDA level change is accepted.

Ports:
- clk  in  1  system clock; must be at least 16x SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low.
- ram_addr  out  ADDR_W  register read/write address (current pointer).
- ram_wdata  out  8  write data.
- ram_we  out  1  one-clk write strobe.
- ram_rdata  in  8  read data; valid 1 clk after ram_addr changes.
- busy  out  1  high from an address-matched START until STOP.
- stop_evt  out  1  one-clk pulse on STOP after a matched transaction.

Behaviour:
- **Reset (reset=0, async):**
  - sda_oe=0, ram_we=0, busy=0, stop_evt=0, ram_addr=0, ram_wdata=0.
  - State=IDLE, filters preset to 1.
  - Reset asserted mid-byte releases SDA immediately.
- **Input conditioning:**
  - 2-flop synchroniser, then FILTER_LEN-deep filter per line.
  - Filtered edges are detected in clk domain: scl_rise, scl_fall.
  - START = filtered SDA falling while SCL high. STOP = filtered SDA rising while SCL high.
  - START/STOP take priority over bit activity in any state.
- **Bit timing:**
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall (never while SCL high).
  - Bits are MSB first.
- **States:** IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: on START -> DEV_ADDR, bit counter cleared.
  - DEV_ADDR: after 8 bits, compare bits[7:1] with SLAVE_ADDR.
    - Mismatch -> IGNORE; no ACK driven.
    - Match -> DEV_ACK; busy=1.
  - DEV_ACK: drive ACK low for the 9th clock.
    - R/W=0 -> PTR.
    - R/W=1 -> load shift register from ram_rdata at the ACK scl_fall -> RD_DATA.
  - PTR: the 8-bit byte is truncated to its low ADDR_W bits and loaded into ram_addr -> PTR_ACK (ACK) -> WR_DATA.
  - WR_DATA: after 8 bits, ram_wdata=byte and ram_we pulses exactly 1 clk at the 8th scl_rise -> WR_ACK (ACK) -> WR_DATA.
    - If AUTO_INC, ram_addr increments modulo 2**ADDR_W at the ACK scl_fall.
  - RD_DATA: shift out 8 bits, then release SDA -> RD_ACK.
    - Master ACK (0): ram_addr increments if AUTO_INC; the next byte is loaded from ram_rdata, valid >=1 clk later, before the first data scl_fall -> RD_DATA.
    - Master NACK (1) -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Repeated START:** from any state -> DEV_ADDR.
  - Pointer is retained, so write-pointer followed by Sr+read reads from the set pointer.
- **STOP:** from any state -> IDLE.
  - busy drops the same clk.
  - stop_evt pulses if busy was 1.
  - Pointer is retained across transactions.
- **Wrap-around:** pointer 2**ADDR_W-1 increments to 0, for both write and read.
- **Collision case:** simultaneous ram_we with START/STOP cannot occur, because the strobe is on scl_rise and START/STOP occur with SCL high and no edge. The implementation asserts this.

Test Plan:
- Write with wrap: START, 0x84 (addr 0x42, W), ptr 0x1E, data 0xA1,0xB2,0xC3, STOP.
  - Expect ram_we x3 at addresses 0x1E, 0x1F, 0x00 with matching data.
  - Expect an ACK on every byte and one stop_evt.
- Pointer-read with repeated START: START, 0x84, ptr 0x1F, Sr, 0x85, read 2 bytes (ACK then NACK), STOP.
  - Expect bytes mem[0x1F], mem[0x00] on SDA.
  - Expect SDA released after the NACK.
- Address mismatch: START, 0x86, data.
  - Expect sda_oe=0 throughout, no ram_we, busy=0, no stop_evt on STOP.
- Glitch rejection: 2-clk low pulse on SDA while SCL high in IDLE (FILTER_LEN=3).
  - Expect no START and state stays IDLE.
  - A 4-clk pulse must be detected as a START.
- Reset mid-read: assert reset while sda_oe=1 during RD_DATA.
  - Expect sda_oe=0 asynchronously, busy=0, ram_addr=0.
  - A following normal write transaction succeeds.
- AUTO_INC=0, ADDR_W=7: write 3 bytes at ptr 0x55.
  - Expect all three writes to 0x55, last value retained.
  - Pointer byte 0xD5 must map to 0x55.

Source files
------------

// File: rtl/i2c_slave_regport.sv
// I2C target: 7-bit address match, register-pointer protocol, optional auto-increment,
// repeated START, glitch-filtered inputs, and a 1-clk-latency register-file port.
module i2c_slave_regport #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         ADDR_W     = 5,
  parameter bit         AUTO_INC   = 1'b1,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              stop_evt
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]            sclSync, sdaSync;
  logic [FILTER_LEN-1:0] sclHist, sdaHist;
  logic                  sclF, sdaF, sclPrev, sdaPrev;

  // A level change is accepted only after FILTER_LEN identical synchronised samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclHist <= '1;
      sdaHist <= '1;
      sclF    <= 1'b1;
      sdaF    <= 1'b1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[0], scl_in};
      sdaSync <= {sdaSync[0], sda_in};
      sclHist <= {sclHist[FILTER_LEN-2:0], sclSync[1]};
      sdaHist <= {sdaHist[FILTER_LEN-2:0], sdaSync[1]};
      if (&sclHist)       sclF <= 1'b1;
      else if (~|sclHist) sclF <= 1'b0;
      if (&sdaHist)       sdaF <= 1'b1;
      else if (~|sdaHist) sdaF <= 1'b0;
      sclPrev <= sclF;
      sdaPrev <= sdaF;
    end
  end

  logic sclRise, sclFall, startDet, stopDet;
  assign sclRise  = sclF & ~sclPrev;
  assign sclFall  = ~sclF & sclPrev;
  assign startDet = sclF & sclPrev & sdaPrev & ~sdaF;
  assign stopDet  = sclF & sclPrev & ~sdaPrev & sdaF;

  state_t     state;
  logic [3:0] bitCnt;
  logic [7:0] shiftReg;
  logic       rwBit;
  logic [7:0] rxByte;
  logic       byteDone;

  assign rxByte   = {shiftReg[6:0], sdaF};
  assign byteDone = (bitCnt == 4'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= 4'd0;
      shiftReg  <= 8'd0;
      rwBit     <= 1'b0;
      sda_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'd0;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      stop_evt  <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      stop_evt <= 1'b0;
      if (stopDet) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_evt <= busy;
      end else if (startDet) begin
        state  <= DEV_ADDR;
        bitCnt <= 4'd0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 4'd1;
            if (byteDone) begin
              bitCnt <= 4'd0;
              if (rxByte[7:1] == SLAVE_ADDR) begin
                state <= DEV_ACK;
                busy  <= 1'b1;
                rwBit <= rxByte[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          PTR: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 4'd1;
            if (byteDone) begin
              bitCnt   <= 4'd0;
              ram_addr <= rxByte[ADDR_W-1:0];
              state    <= PTR_ACK;
            end
          end
          WR_DATA: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 4'd1;
            if (byteDone) begin
              bitCnt    <= 4'd0;
              ram_wdata <= rxByte;
              ram_we    <= 1'b1;
              state     <= WR_ACK;
            end
          end
          // ACK states: first fall starts the ACK, second fall ends the 9th clock.
          DEV_ACK: if (sclFall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rwBit) begin
              shiftReg <= {ram_rdata[6:0], 1'b0};
              sda_oe   <= ~ram_rdata[7];
              bitCnt   <= 4'd0;
              state    <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= PTR;
            end
          end
          PTR_ACK: if (sclFall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          WR_ACK: if (sclFall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              if (AUTO_INC) ram_addr <= ram_addr + ADDR_ONE;
              state  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (sclRise) begin
              bitCnt <= bitCnt + 4'd1;
            end else if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sda_oe <= 1'b0;
                bitCnt <= 4'd0;
                state  <= RD_ACK;
              end else begin
                sda_oe   <= ~shiftReg[7];
                shiftReg <= {shiftReg[6:0], 1'b0};
              end
            end
          end
          // Pointer bumps at the master ACK rise so ram_rdata settles before the reload fall.
          RD_ACK: begin
            if (sclRise) begin
              if (!sdaF) begin
                if (AUTO_INC) ram_addr <= ram_addr + ADDR_ONE;
              end else begin
                state <= IGNORE;
              end
            end else if (sclFall) begin
              shiftReg <= {ram_rdata[6:0], 1'b0};
              sda_oe   <= ~ram_rdata[7];
              bitCnt   <= 4'd0;
              state    <= RD_DATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Write strobe follows an SCL rise; START/STOP need SCL stable high, so they never coincide.
  assert property (@(posedge clk) disable iff (!reset) !(ram_we && (startDet || stopDet)));

endmodule

// File: tb/tb_i2c_slave_regport.sv
// Directed bench: bit-banged I2C master on a shared open-drain bus with two targets
// (auto-increment 5-bit pointer at 0x42, fixed 7-bit pointer at 0x21).
module tb_i2c_slave_regport;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl = 1'b1;
  logic sdaM = 1'b1;
  logic oeA, oeB, weA, weB, busyA, busyB, stopA, stopB;
  logic [4:0] addrA;
  logic [6:0] addrB;
  logic [7:0] wdA, wdB, rdA, rdB;
  wire sdaBus = sdaM & ~oeA & ~oeB;

  always #5 clk = ~clk;

  i2c_slave_regport #(.SLAVE_ADDR(7'h42), .ADDR_W(5), .AUTO_INC(1'b1), .FILTER_LEN(3)) dutA (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sdaBus), .sda_oe(oeA),
    .ram_addr(addrA), .ram_wdata(wdA), .ram_we(weA), .ram_rdata(rdA),
    .busy(busyA), .stop_evt(stopA));

  i2c_slave_regport #(.SLAVE_ADDR(7'h21), .ADDR_W(7), .AUTO_INC(1'b0), .FILTER_LEN(3)) dutB (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sdaBus), .sda_oe(oeB),
    .ram_addr(addrB), .ram_wdata(wdB), .ram_we(weB), .ram_rdata(rdB),
    .busy(busyB), .stop_evt(stopB));

  typedef struct { int addr; logic [7:0] data; } wr_t;
  wr_t wrA[$];
  wr_t wrB[$];
  logic [7:0] memA [32];
  logic [7:0] memB [128];
  int stopCntA = 0, stopCntB = 0;
  logic oeSeenA = 1'b0;
  int nTests = 0, nFail = 0;

  // Register-file models with 1-clk read latency, plus write/stop capture.
  always @(posedge clk) begin
    if (weA) begin memA[addrA] <= wdA; wrA.push_back('{int'(addrA), wdA}); end
    if (weB) begin memB[addrB] <= wdB; wrB.push_back('{int'(addrB), wdB}); end
    rdA <= memA[addrA];
    rdB <= memB[addrB];
    if (stopA) stopCntA++;
    if (stopB) stopCntB++;
    if (oeA) oeSeenA = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2cStart();
    sdaM = 1'b1; tick(Q);
    scl = 1'b1;  tick(2*Q);
    sdaM = 1'b0; tick(2*Q);
    scl = 1'b0;  tick(Q);
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; tick(Q);
    scl = 1'b1;  tick(2*Q);
    sdaM = 1'b1; tick(2*Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sdaM = b[i]; tick(Q);
      scl = 1'b1;  tick(2*Q);
      scl = 1'b0;  tick(Q);
    end
    sdaM = 1'b1; tick(Q);
    scl = 1'b1;  tick(Q);
    ack = sdaBus; tick(Q);
    scl = 1'b0;  tick(Q);
  endtask

  task automatic readByte(input logic ackBit, output logic [7:0] b);
    sdaM = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl = 1'b1; tick(Q);
      b[i] = sdaBus; tick(Q);
      scl = 1'b0; tick(Q);
    end
    sdaM = ackBit; tick(Q);
    scl = 1'b1;    tick(2*Q);
    scl = 1'b0;    tick(Q);
  endtask

  typedef struct {
    logic [7:0] dev, ptr, data;
    logic       expAck;
    logic [4:0] expAddr;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic a0, a1, a2, a3, a4;
    logic [7:0] b0, b1;
    int n0, s0;
    logic found;

    vecs[0] = '{8'h84, 8'h03, 8'h5A, 1'b1, 5'h03};
    vecs[1] = '{8'h84, 8'hE7, 8'h3C, 1'b1, 5'h07};
    vecs[2] = '{8'h86, 8'h10, 8'h99, 1'b0, 5'h00};
    vecs[3] = '{8'h84, 8'h1F, 8'hFF, 1'b1, 5'h1F};
    vecs[4] = '{8'h84, 8'h40, 8'h12, 1'b1, 5'h00};
    for (int i = 0; i < 32; i++) memA[i] = 8'h00;
    for (int i = 0; i < 128; i++) memB[i] = 8'h00;

    // Reset state
    tick(3);
    check("rst_sda_oe", 32'(oeA), 0);
    check("rst_busy", 32'(busyA), 0);
    check("rst_ram_addr", 32'(addrA), 0);
    check("rst_ram_we", 32'(weA), 0);
    check("rst_stop_evt", 32'(stopA), 0);
    check("rst_ram_wdata", 32'(wdA), 0);
    reset = 1'b1;
    tick(10);

    // Single-byte write vectors
    for (int v = 0; v < 5; v++) begin
      n0 = wrA.size(); s0 = stopCntA;
      i2cStart();
      sendByte(vecs[v].dev, a0);
      sendByte(vecs[v].ptr, a1);
      sendByte(vecs[v].data, a2);
      i2cStop();
      check($sformatf("vec%0d_acks", v), 32'({a0, a1, a2}), vecs[v].expAck ? 0 : 7);
      check($sformatf("vec%0d_wecount", v), 32'(wrA.size() - n0), vecs[v].expAck ? 1 : 0);
      check($sformatf("vec%0d_stopevt", v), 32'(stopCntA - s0), vecs[v].expAck ? 1 : 0);
      if (vecs[v].expAck && wrA.size() > n0) begin
        check($sformatf("vec%0d_waddr", v), 32'(wrA[n0].addr), 32'(vecs[v].expAddr));
        check($sformatf("vec%0d_wdata", v), 32'(wrA[n0].data), 32'(vecs[v].data));
      end
    end

    // Write with pointer wrap
    n0 = wrA.size(); s0 = stopCntA;
    i2cStart();
    sendByte(8'h84, a0);
    sendByte(8'h1E, a1);
    check("wrap_busy_mid", 32'(busyA), 1);
    sendByte(8'hA1, a2);
    sendByte(8'hB2, a3);
    sendByte(8'hC3, a4);
    i2cStop();
    check("wrap_acks", 32'({a0, a1, a2, a3, a4}), 0);
    check("wrap_wecount", 32'(wrA.size() - n0), 3);
    if (wrA.size() >= n0 + 3) begin
      check("wrap_w0", 32'({wrA[n0].addr[7:0], wrA[n0].data}), 32'h1EA1);
      check("wrap_w1", 32'({wrA[n0+1].addr[7:0], wrA[n0+1].data}), 32'h1FB2);
      check("wrap_w2", 32'({wrA[n0+2].addr[7:0], wrA[n0+2].data}), 32'h00C3);
    end
    check("wrap_stopevt", 32'(stopCntA - s0), 1);
    check("wrap_busy_after", 32'(busyA), 0);

    // Pointer write, repeated START, read with ACK then NACK
    s0 = stopCntA;
    i2cStart();
    sendByte(8'h84, a0);
    sendByte(8'h1F, a1);
    i2cStart();
    sendByte(8'h85, a2);
    readByte(1'b0, b0);
    readByte(1'b1, b1);
    check("rd_sda_released", 32'(oeA), 0);
    i2cStop();
    check("rd_acks", 32'({a0, a1, a2}), 0);
    check("rd_byte0", 32'(b0), 32'hB2);
    check("rd_byte1", 32'(b1), 32'hC3);
    check("rd_stopevt", 32'(stopCntA - s0), 1);

    // Address mismatch
    n0 = wrA.size(); s0 = stopCntA; oeSeenA = 1'b0;
    i2cStart();
    sendByte(8'h86, a0);
    sendByte(8'h55, a1);
    check("mm_busy", 32'(busyA), 0);
    i2cStop();
    check("mm_acks", 32'({a0, a1}), 3);
    check("mm_oe_seen", 32'(oeSeenA), 0);
    check("mm_we", 32'(wrA.size() - n0), 0);
    check("mm_stopevt", 32'(stopCntA - s0), 0);

    // Glitch: 2-clk SDA low pulse with SCL high must not start a transaction
    s0 = stopCntA;
    sdaM = 1'b0; tick(2);
    sdaM = 1'b1; tick(Q);
    scl = 1'b0;  tick(Q);
    sendByte(8'h84, a0);
    i2cStop();
    check("glitch2_nack", 32'(a0), 1);
    check("glitch2_stopevt", 32'(stopCntA - s0), 0);
    // 4-clk low pulse is a real START
    sdaM = 1'b0; tick(4);
    scl = 1'b0;  tick(Q);
    sendByte(8'h84, a0);
    i2cStop();
    check("glitch4_ack", 32'(a0), 0);
    check("glitch4_stopevt", 32'(stopCntA - s0), 1);

    // Reset while driving read data
    i2cStart();
    sendByte(8'h84, a0);
    sendByte(8'h00, a1);
    i2cStart();
    sendByte(8'h85, a2);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(Q);
      scl = 1'b1; tick(2*Q);
      scl = 1'b0; tick(Q);
      if (oeA) found = 1'b1;
    end
    check("rstrd_driving", 32'(found), 1);
    #3 reset = 1'b0;
    #1;
    check("rstrd_sda_oe", 32'(oeA), 0);
    check("rstrd_busy", 32'(busyA), 0);
    check("rstrd_ram_addr", 32'(addrA), 0);
    scl = 1'b1; sdaM = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(10);
    n0 = wrA.size(); s0 = stopCntA;
    i2cStart();
    sendByte(8'h84, a0);
    sendByte(8'h05, a1);
    sendByte(8'h77, a2);
    i2cStop();
    check("post_rst_acks", 32'({a0, a1, a2}), 0);
    check("post_rst_wecount", 32'(wrA.size() - n0), 1);
    if (wrA.size() > n0)
      check("post_rst_write", 32'({wrA[n0].addr[7:0], wrA[n0].data}), 32'h0577);
    check("post_rst_stopevt", 32'(stopCntA - s0), 1);

    // Fixed pointer, 7-bit address space
    n0 = wrB.size(); s0 = stopCntB;
    i2cStart();
    sendByte(8'h42, a0);
    sendByte(8'hD5, a1);
    sendByte(8'h11, a2);
    sendByte(8'h22, a3);
    sendByte(8'h33, a4);
    i2cStop();
    tick(2);
    check("noinc_acks", 32'({a0, a1, a2, a3, a4}), 0);
    check("noinc_wecount", 32'(wrB.size() - n0), 3);
    if (wrB.size() >= n0 + 3) begin
      check("noinc_w0", 32'({wrB[n0].addr[7:0], wrB[n0].data}), 32'h5511);
      check("noinc_w1", 32'({wrB[n0+1].addr[7:0], wrB[n0+1].data}), 32'h5522);
      check("noinc_w2", 32'({wrB[n0+2].addr[7:0], wrB[n0+2].data}), 32'h5533);
    end
    check("noinc_mem", 32'(memB[7'h55]), 32'h33);
    check("noinc_stopevt", 32'(stopCntB - s0), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
